// File: rtl/coder_miller_tx.sv
// coder_miller_tx: Miller (delay-modulation) serial transmitter with valid/ready word input.
// Optional feature macro: CODER_MILLER_PARITY_EN (appends an even-parity bit to every frame).
// Ports:
//    clk_100m  - clock, all registers on its rising edge
//    rst_n     - asynchronous active-low reset
//    data_i    - DATA_W-bit word, captured on valid_i && ready_o
//    valid_i   - data_i is valid
//    ready_o   - a word can be accepted this cycle
//    miller_o  - registered Miller line level
//    busy_o    - a frame is on the line
//    done_o    - one-cycle pulse in the last cycle of a frame
module coder_miller_tx #(
   parameter int DATA_W       = 8,
   parameter int HALF_BIT_CYC = 5,
   parameter int MSB_FIRST    = 1
) (
   input  logic              clk_100m,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              miller_o,
   output logic              busy_o,
   output logic              done_o
);
   localparam int HW = HALF_BIT_CYC > 1 ? $clog2(HALF_BIT_CYC) : 1;
   localparam int BW = $clog2(DATA_W + 1);
`ifdef CODER_MILLER_PARITY_EN
   localparam int FW = DATA_W + 1;
`else
   localparam int FW = DATA_W;
`endif
   typedef enum logic [1:0] {IDLE, FIRST_HALF, SECOND_HALF} state_t;
   state_t          state, state_n;
   logic [HW-1:0]   half_cnt;
   logic [BW-1:0]   bit_idx;
   logic [FW-1:0]   sr, sr_sh, ld;
   logic            half_last, bit_end, last, accept;
   logic            cur_bit, nxt_bit, ld_bit, prev_bit;
`ifdef CODER_MILLER_PARITY_EN
   assign ld = (MSB_FIRST != 0) ? {data_i, ^data_i} : {^data_i, data_i};
`else
   assign ld = data_i;
`endif
   assign half_last = half_cnt == HW'(HALF_BIT_CYC - 1);
   assign bit_end   = state == SECOND_HALF && half_last;
   assign last      = bit_end && bit_idx == BW'(FW - 1);
   assign ready_o   = state == IDLE || last;
   assign busy_o    = state != IDLE;
   assign done_o    = last;
   assign accept    = valid_i && ready_o;
   assign sr_sh     = (MSB_FIRST != 0) ? sr << 1 : sr >> 1;
   assign cur_bit   = (MSB_FIRST != 0) ? sr[FW-1] : sr[0];
   assign nxt_bit   = (MSB_FIRST != 0) ? sr_sh[FW-1] : sr_sh[0];
   assign ld_bit    = (MSB_FIRST != 0) ? ld[FW-1] : ld[0];
   // Bit sent before the one about to start: forced to 1 after idle, otherwise the
   // current bit, which also carries line-code continuity into a back-to-back frame.
   assign prev_bit  = state == IDLE ? 1'b1 : cur_bit;
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:        state_n = accept ? FIRST_HALF : IDLE;
         FIRST_HALF:  state_n = half_last ? SECOND_HALF : FIRST_HALF;
         SECOND_HALF: state_n = !half_last ? SECOND_HALF : (last && !accept) ? IDLE : FIRST_HALF;
         default:     state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         half_cnt <= '0;
         bit_idx  <= '0;
         sr       <= '0;
         miller_o <= 1'b0;
      end else begin
         half_cnt <= (state == IDLE || half_last) ? '0 : half_cnt + 1'b1;
         if (accept) begin
            sr       <= ld;
            bit_idx  <= '0;
            miller_o <= miller_o ^ (!ld_bit && !prev_bit);
         end else if (bit_end) begin
            sr       <= sr_sh;
            bit_idx  <= bit_idx + 1'b1;
            // Boundary toggle for a 0 that follows a 0; the line holds when going idle.
            if (!last) miller_o <= miller_o ^ (!nxt_bit && !cur_bit);
         end else if (state == FIRST_HALF && half_last) begin
            miller_o <= miller_o ^ cur_bit;
         end
      end
   end
endmodule

// File: tb/tb_coder_miller_tx.sv
// tb_coder_miller_tx: randomized check of coder_miller_tx against a half-bit level queue model.
module tb_coder_miller_tx;
   localparam int DW = 4;
   localparam int H  = 2;
   logic          clk_100m = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid = 1'b0;
   logic [DW-1:0] data = '0;
   logic [DW-1:0] data_r;
   logic          rdy_a, m_a, busy_a, done_a;
   logic          rdy_b, m_b, busy_b, done_b;
   bit            q[$];
   bit            idle_lvl = 1'b0;
   bit            last_bit = 1'b1;
   int            tests = 0;
   int            fails = 0;
   always #5 clk_100m = ~clk_100m;
   always_comb begin
      data_r = '0;
      for (int i = 0; i < DW; i++) data_r[i] = data[DW-1-i];
   end
   coder_miller_tx #(.DATA_W(DW), .HALF_BIT_CYC(H), .MSB_FIRST(1)) u_msb (
      .clk_100m(clk_100m), .rst_n(rst_n), .data_i(data), .valid_i(valid),
      .ready_o(rdy_a), .miller_o(m_a), .busy_o(busy_a), .done_o(done_a));
   // LSB-first instance gets the bit-reversed word, so it must produce the identical waveform.
   coder_miller_tx #(.DATA_W(DW), .HALF_BIT_CYC(H), .MSB_FIRST(0)) u_lsb (
      .clk_100m(clk_100m), .rst_n(rst_n), .data_i(data_r), .valid_i(valid),
      .ready_o(rdy_b), .miller_o(m_b), .busy_o(busy_b), .done_o(done_b));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask
   task automatic check_all();
      bit em;
      em = q.size() > 0 ? q[0] : idle_lvl;
      chk("msb_miller", m_a, em);
      chk("msb_ready", rdy_a, q.size() <= 1);
      chk("msb_busy", busy_a, q.size() > 0);
      chk("msb_done", done_a, q.size() == 1);
      chk("lsb_miller", m_b, em);
      chk("lsb_ready", rdy_b, q.size() <= 1);
      chk("lsb_busy", busy_b, q.size() > 0);
      chk("lsb_done", done_b, q.size() == 1);
   endtask
   // Miller rules on the bit list: 0 after 0 toggles at bit start, 1 toggles at mid-bit.
   task automatic push_frame(input logic [DW-1:0] d, input bit was_busy);
      bit bits[$];
      bit prv, lvl;
      for (int i = DW - 1; i >= 0; i--) bits.push_back(d[i]);
`ifdef CODER_MILLER_PARITY_EN
      bits.push_back(^d);
`endif
      prv = was_busy ? last_bit : 1'b1;
      lvl = idle_lvl;
      foreach (bits[k]) begin
         if (!bits[k] && !prv) lvl = !lvl;
         repeat (H) q.push_back(lvl);
         if (bits[k]) lvl = !lvl;
         repeat (H) q.push_back(lvl);
         prv = bits[k];
      end
      last_bit = prv;
   endtask
   task automatic step(input bit v, input logic [DW-1:0] d);
      bit acc, was_busy;
      @(negedge clk_100m);
      check_all();
      valid = v;
      data  = d;
      acc = v && q.size() <= 1;
      was_busy = q.size() > 0;
      if (was_busy) begin
         idle_lvl = q[0];
         void'(q.pop_front());
      end
      if (acc) push_frame(d, was_busy);
   endtask
   task automatic do_reset(input int cyc);
      @(negedge clk_100m);
      rst_n = 1'b0;
      valid = 1'b0;
      q.delete();
      idle_lvl = 1'b0;
      last_bit = 1'b1;
      #1 check_all();
      repeat (cyc) begin
         @(negedge clk_100m);
         check_all();
      end
      rst_n = 1'b1;
   endtask
   initial begin
      do_reset(3);
      repeat (3) step(1'b0, '0);
      step(1'b1, 4'b1010);
      repeat (18) step(1'b0, '0);
      step(1'b1, 4'b0000);
      repeat (18) step(1'b0, '0);
      step(1'b1, 4'b1010);
      repeat (24) step(1'b1, 4'b0000);
      repeat (24) step(1'b0, '0);
      step(1'b1, 4'b1010);
      repeat (10) step(1'b0, '0);
      do_reset(2);
      step(1'b1, 4'b0110);
      repeat (24) step(1'b0, '0);
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 3) != 0, DW'($urandom));
         if ($urandom_range(0, 400) == 0) do_reset($urandom_range(0, 2));
      end
      repeat (30) step(1'b0, '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/coder_miller_tx.md
# coder_miller_tx

Parametrised Miller (delay-modulation) transmitter for the coder datapath. Accepts parallel words over a valid/ready handshake, serialises them, and drives the Miller line code with a programmable bit period derived from `clk_100m`. Back-to-back frames stream without a gap and keep line-code continuity across word boundaries.

## Interface
Parameters:
- `DATA_W`, 8: bits per word; legal range 1–32.
- `HALF_BIT_CYC`, 5: `clk_100m` cycles per half bit, minimum 1. Bit period is 2×`HALF_BIT_CYC` cycles.
- `MSB_FIRST`, 1: 1 transmits `data_i[DATA_W-1]` first; 0 transmits `data_i[0]` first.

Ports:
- `clk_100m` input 1: single clock; every register is on its rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `data_i` input `DATA_W`: word to send, sampled on handshake.
- `valid_i` input 1: `data_i` is valid.
- `ready_o` output 1: block can accept a word this cycle.
- `miller_o` output 1: registered Miller line output.
- `busy_o` output 1: a frame is being transmitted.
- `done_o` output 1: one-cycle pulse in the final cycle of a frame.

## Operation
- Encoding rules, applied per bit:
  - Bit 1: level toggles at mid-bit.
  - Bit 0: no mid-bit toggle.
  - Bit 0 immediately preceded by bit 0: level also toggles at the bit start.
- `prev_bit` tracks the previously sent bit.
  - Set to 1 on reset.
  - Set to 1 on every IDLE→FIRST_HALF entry, so the first 0 after idle has no boundary toggle.
  - Carried unchanged across back-to-back frames.
- States:
  - IDLE: `ready_o`=1 and `busy_o`=0; `miller_o` holds its last level.
  - FIRST_HALF: lasts `HALF_BIT_CYC` cycles.
  - SECOND_HALF: lasts `HALF_BIT_CYC` cycles.
- Transitions:
  - IDLE→FIRST_HALF on `valid_i && ready_o`. The word is loaded into the shift register and the bit index is set to 0.
  - FIRST_HALF→SECOND_HALF when the half counter reaches `HALF_BIT_CYC-1`.
  - SECOND_HALF→FIRST_HALF on the same counter condition. The bit index increments and `prev_bit` takes the current bit.
  - After the last bit's SECOND_HALF: if a handshake occurs in that cycle, go to FIRST_HALF with the new word; otherwise go to IDLE.
- `ready_o`=1 in IDLE and in the last cycle of the last bit's SECOND_HALF; 0 otherwise.
- `valid_i` while `ready_o`=0 is ignored. `data_i` changes after capture have no effect.
- Counters:
  - Half counter is `$clog2(HALF_BIT_CYC)` bits wide, minimum 1, and wraps to 0.
  - Bit index is `$clog2(DATA_W+1)` bits wide, minimum 1.
- Reset mid-frame: all state returns to reset values immediately. The partial frame is discarded, with no completion of the current bit.

## Timing
- Reset values:
  - `miller_o`=0, `ready_o`=1, `busy_o`=0, `done_o`=0.
  - State IDLE, counters 0, `prev_bit`=1.
- Latency: the level for bit 0's first half appears on `miller_o` in the cycle after the handshake edge. A boundary toggle takes effect in that same cycle.
- Mid-bit toggle appears exactly `HALF_BIT_CYC` cycles after the bit's first-half level.
- Frame length is N×2×`HALF_BIT_CYC` cycles.
  - N = `DATA_W` without parity; N = `DATA_W`+1 with parity.
- `done_o` pulses in the last frame cycle, coincident with `ready_o`=1.
- A back-to-back accept in that cycle makes the next frame's first bit start on the very next cycle, with zero idle cycles.
- `busy_o` is high from the cycle after the handshake through the last frame cycle.

## Configuration
- `CODER_MILLER_PARITY_EN` defined:
  - An even-parity bit (XOR of all data bits) is appended after the last data bit.
  - The parity bit is encoded with the same rules.
  - Frame is `DATA_W`+1 bits; `done_o` and `ready_o` move to the end of the parity bit.
- `CODER_MILLER_PARITY_EN` undefined: frame is exactly `DATA_W` bits and no parity logic is present.

## Test plan
All scenarios list `miller_o` per half bit.
- Reset then idle:
  - Stimulus: `rst_n` low, then high, with no `valid_i`.
  - Required: `miller_o`=0, `ready_o`=1, `busy_o`=0, `done_o`=0 throughout.
- Ones and zeros, parity off:
  - Settings: `DATA_W`=4, `HALF_BIT_CYC`=2, `MSB_FIRST`=1; stimulus `data_i`=4'b1010.
  - Required: 0,1,1,1,1,0,0,0, each level held 2 cycles.
  - `done_o` pulses once at cycle 16 after the handshake.
- Consecutive zeros, parity off:
  - Settings as above; stimulus `data_i`=4'b0000 from idle level 0.
  - Required: 0,0,1,1,0,0,1,1, i.e. boundary toggles only on bits 2–4.
- Back-to-back:
  - Stimulus: hold `valid_i`=1 and send 4'b1010 then 4'b0000.
  - Required: no idle cycle between frames.
  - The second frame's first 0 toggles at its start (`prev_bit`=0 carried), giving 1,1,0,0,1,1,0,0.
- Parity on:
  - Stimulus: `CODER_MILLER_PARITY_EN` defined, 4'b1010.
  - Required: data halves as in the ones-and-zeros scenario, then parity 0 with a boundary toggle giving 1,1.
  - `done_o` at cycle 20.
- Reset mid-frame and LSB-first:
  - Stimulus: assert `rst_n` low during bit 2.
  - Required: outputs return to reset values within the same cycle, and the next frame starts clean.
  - With `MSB_FIRST`=0, 4'b0101 produces the same waveform as 4'b1010 MSB-first.
